// File: rtl/result_drain.sv
// Result drain: reads NUM_RES words from result memory on a done edge
// and streams them out through a 2-entry FIFO with index and last flag.
module result_drain #(
    parameter int                ADDR_W   = 7,
    parameter int                DATA_W   = 34,
    parameter logic [ADDR_W-1:0] RES_BASE = 7'd64,
    parameter int                NUM_RES  = 8,
    parameter int                IDX_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done_in,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [IDX_W-1:0]  m_index,
    output logic              m_last,
    output logic              busy,
    output logic              drain_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  issue_idx_q, issue_idx_d;
    logic              done_prev_q;
    logic              inflight_q;
    logic [IDX_W-1:0]  infl_idx_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        cnt_q, cnt_d;
    logic              rd_ptr_q;
    logic              wr_ptr_q;
    logic [DATA_W-1:0] fifo_data_q [2];
    logic [IDX_W-1:0]  fifo_idx_q  [2];
    logic              drain_done_q;

    logic              trig;
    logic              pop;
    logic              push;
    logic              issue;
    logic              last_pop;
    logic [2:0]        occ;
    logic [IDX_W-1:0]  head_idx;
    logic [ADDR_W-1:0] rd_addr;

    assign trig     = done_in & ~done_prev_q;
    assign pop      = m_valid & m_ready;
    assign push     = inflight_q;
    assign head_idx = fifo_idx_q[rd_ptr_q];
    assign last_pop = pop & (head_idx == LAST_IDX);
    assign rd_addr  = RES_BASE + ADDR_W'(issue_idx_q);

    // Occupancy counts the word still in the memory pipe; a same-cycle
    // pop frees a slot so reads continue back-to-back at full rate.
    assign occ   = {1'b0, cnt_q} + {2'b00, inflight_q};
    assign issue = (state_q == S_READ) && (occ < (3'd2 + {2'b00, pop}));
    assign cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

    always_comb begin
        state_d     = state_q;
        issue_idx_d = issue_idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (trig) begin
                    state_d     = S_READ;
                    issue_idx_d = '0;
                end
            end
            S_READ: begin
                if (issue) begin
                    if (issue_idx_q == LAST_IDX) begin
                        state_d     = S_FLUSH;
                        issue_idx_d = '0;
                    end else begin
                        issue_idx_d = issue_idx_q + 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (last_pop) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            issue_idx_q    <= '0;
            done_prev_q    <= 1'b0;
            inflight_q     <= 1'b0;
            infl_idx_q     <= '0;
            addr_q         <= '0;
            cnt_q          <= '0;
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_idx_q[0]  <= '0;
            fifo_idx_q[1]  <= '0;
            drain_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            issue_idx_q  <= issue_idx_d;
            done_prev_q  <= done_in;
            inflight_q   <= issue;
            cnt_q        <= cnt_d;
            drain_done_q <= (state_q == S_FLUSH) & last_pop;
            if (issue) begin
                infl_idx_q <= issue_idx_q;
                addr_q     <= rd_addr;
            end
            if (push) begin
                fifo_data_q[wr_ptr_q] <= mem_read_data;
                fifo_idx_q[wr_ptr_q]  <= infl_idx_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
        end
    end

    assign mem_rd_en   = issue;
    assign mem_address = issue ? rd_addr : addr_q;
    assign m_valid     = (cnt_q != 2'd0);
    assign m_data      = fifo_data_q[rd_ptr_q];
    assign m_index     = head_idx;
    assign m_last      = m_valid & (head_idx == LAST_IDX);
    assign busy        = (state_q != S_IDLE);
    assign drain_done  = drain_done_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (cnt_q == 2'd2) && !pop));

endmodule

// File: doc/result_drain.md
Name: result_drain

Overview:
- Downstream stage of the bit-serial matrix-vector engine.
- When the engine's `done` is seen, the block reads NUM_RES result words from the shared result memory, starting at RES_BASE.
- It streams the words out on a valid/ready interface, in index order, with a last flag.
- A 2-entry output FIFO absorbs back-pressure, so the memory port never stalls against an unread word.

Parameters:
- ADDR_W, 7, memory address width.
- DATA_W, 34, memory/result word width.
- RES_BASE, 7'd64, address of result word 0.
- NUM_RES, 8, number of result words (one per matrix row).
- IDX_W, 3, width of the index counter; must satisfy 2**IDX_W >= NUM_RES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- done_in  in  1  engine completion, level or pulse; only its rising edge triggers a drain.
- mem_rd_en  out  1  memory read request.
- mem_address  out  ADDR_W  read address, = RES_BASE + issue index.
- mem_read_data  in  DATA_W  read data, valid exactly 1 cycle after the mem_rd_en cycle (registered read).
- m_valid  out  1  output word available.
- m_ready  in  1  consumer accepts the word.
- m_data  out  DATA_W  result word.
- m_index  out  IDX_W  row index of m_data.
- m_last  out  1  high with the word whose index is NUM_RES-1.
- busy  out  1  high from trigger until the last word is accepted.
- drain_done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset: all outputs are 0, FIFO is emptied, counters are cleared, state is IDLE, and done_prev=0.
  - Reset asserted mid-drain aborts immediately.
  - In-flight read data on the following cycle is discarded.
- Trigger: trig = done_in & ~done_prev, where done_prev is registered every cycle.
  - trig in IDLE moves to READ and sets busy=1.
  - trig in any other state is ignored.
- States:
  - IDLE: wait for trig.
  - READ: issue reads.
  - FLUSH: all reads issued; wait for the FIFO to empty.
  - Return to IDLE after the last word is accepted.
- Issue rule, in READ:
  - mem_rd_en=1 when fifo_count + inflight - pop < 2, where pop = m_valid & m_ready in the same cycle.
  - Each issue increments issue_idx.
  - The issue with issue_idx = NUM_RES-1 moves to FLUSH.
  - mem_rd_en=0 in all other states.
  - mem_address holds its last value when mem_rd_en=0.
- inflight: set to 1 in the cycle after an issue. On that cycle mem_read_data is written to the FIFO tail, tagged with its index.
- FIFO:
  - 2 entries, each holding {index, data}.
  - Simultaneous push and pop is allowed at any count.
  - Overflow is impossible by the issue rule. A push when full is an assertion failure.
- Output:
  - m_valid = (fifo_count != 0). m_data, m_index and m_last come from the FIFO head.
  - Outputs must hold stable while m_valid & ~m_ready.
- Completion:
  - Pop of the entry with index NUM_RES-1 goes to IDLE and clears busy at the next edge.
  - drain_done=1 for exactly that next cycle.
- Latency and throughput:
  - Trigger sampled in cycle 0 → first read in cycle 1 → data captured at the end of cycle 2 → m_valid=1 in cycle 3.
  - With m_ready held high: 1 word/cycle, no bubbles.
- Wrap: the address is computed at ADDR_W bits, modulo 2**ADDR_W. The index counter never exceeds NUM_RES-1.
- done_in held high across the end of a drain does not retrigger. A new rising edge is required.

Test Plan:
- Continuous ready:
  - Stimulus: memory[64..71]=34'h1_0000_0000+i, done_in rises at cycle 0, m_ready=1.
  - Response: m_valid at cycles 3..10 with m_data=34'h1_0000_0000+i and m_index=i; m_last only at cycle 10; drain_done at cycle 11; busy low from cycle 11.
- Back-pressure:
  - Stimulus: m_ready=0 for cycles 3..9, then 1.
  - Response: issue stops after 2 outstanding words; word 0 holds stable; mem_rd_en resumes on the pop cycle; all 8 words arrive in order, no loss or duplication.
- Alternating ready:
  - Stimulus: m_ready toggles 1,0,1,0...
  - Response: exactly 8 handshakes with indices 0..7; m_last only with index 7; drain_done a single pulse.
- Retrigger:
  - Stimulus: done_in pulses again at cycle 5, and is also held high across the end of the drain.
  - Response: neither causes an extra drain. A fresh 0→1 after IDLE starts a new 8-word drain at address 64.
- Reset mid-drain:
  - Stimulus: rst=1 at cycle 6 for 1 cycle.
  - Response: the cycle after, m_valid=0, busy=0, mem_rd_en=0, no drain_done. The next trigger restarts at index 0 / address 64.
- Parameter sweep:
  - Stimulus: NUM_RES=5, RES_BASE=7'd126.
  - Response: addresses 126,127,0,1,2; m_last with index 4.
